nibble_serial_sub: RTL and testbench
====================================

Name: nibble_serial_sub

Overview:
- Multi-cycle signed/unsigned subtractor. Computes diff = a - b - bin one DIGIT-wide slice per clock, LSB slice first, with a registered borrow chain.
- It is the subtract-direction companion of the single-cycle carry-select adder in the ALU datapath.
- It serves area-constrained ALU slots where latency is acceptable.
- It uses a start/busy/done handshake and reports borrow-out and signed overflow.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a positive multiple of DIGIT.
- DIGIT, 4, bits processed per clock cycle; slice count N = WIDTH/DIGIT.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  minuend; captured on an accepted start.
- b  input  WIDTH  subtrahend; captured on an accepted start.
- bin  input  1  borrow-in; captured on an accepted start.
- busy  output  1  high in RUN and DONE states.
- done  output  1  one-cycle completion pulse.
- diff  output  WIDTH  result; held until the next completion.
- bout  output  1  unsigned borrow-out; 1 iff a < b + bin, all values unsigned.
- overflow  output  1  signed overflow flag.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - busy=0, done=0, diff=0, bout=0, overflow=0.
  - All internal operand, shift and borrow registers are cleared.
  - Reset asserted mid-operation aborts it: no done pulse, and no partial result appears on diff.
- States: IDLE, RUN, DONE.
- IDLE:
  - When start=1 at an edge, latch a, b and bin, clear the slice counter, and go to RUN.
  - start=0 leaves the state in IDLE.
- RUN:
  - Each edge computes slice k (k=0..N-1): a_slice - b_slice - borrow.
  - The result slice is shifted into an internal result register.
  - The slice's borrow is registered for slice k+1.
  - After slice N-1, at the same edge:
    - diff takes the full result.
    - bout takes the final borrow.
    - overflow is computed.
    - State goes to DONE and done is set to 1.
  - RUN lasts exactly N edges (N=8 at defaults).
- DONE: done=1 for exactly one cycle, then state returns to IDLE and done returns to 0.
- Latency: start is sampled at edge E0; done is high between edges E0+N and E0+N+1. Minimum start-to-start interval is N+2 cycles.
- start while busy=1 (RUN or DONE) is ignored with no side effects. Changes to a, b or bin after capture have no effect.
- Arithmetic: diff = (a - b - bin) mod 2^WIDTH.
- overflow = (a[MSB] != b[MSB]) && (raw_diff[MSB] != a[MSB]).
- diff, bout and overflow change only on entry to DONE or on reset. Between operations they hold the last result.
- No wrap-around sign correction is applied to diff; it is always the raw modular difference unless the optional feature is compiled in.

Optional Feature:
- Macro: NIBBLE_SERIAL_SUB_SAT_EN.
- Defined: on signed overflow, diff saturates instead of taking the modular value.
  - If a[MSB]=0, diff = 2^(WIDTH-1)-1.
  - If a[MSB]=1, diff = 2^(WIDTH-1).
  - overflow is still asserted. bout is unaffected and computed from the unsaturated arithmetic.
- Undefined: diff is always the modular result.
- Latency is identical in both builds.

Test Plan:
- a=5, b=3, bin=0, start at E0 → done high only between E8 and E9; diff=0x00000002, bout=0, overflow=0; busy high from E0 to E9.
- a=10, b=3, bin=1 → diff=0x00000006, bout=0, overflow=0.
- a=0, b=1, bin=0 → diff=0xFFFFFFFF, bout=1, overflow=0.
- a=0x80000000, b=1, bin=0 → overflow=1, bout=0. diff=0x7FFFFFFF without the macro; diff=0x80000000 with NIBBLE_SERIAL_SUB_SAT_EN.
- a=0x7FFFFFFF, b=0xFFFFFFFF, bin=0 → overflow=1, bout=1. diff=0x80000000 without the macro; diff=0x7FFFFFFF with it.
- Start with a=5, b=3; pulse rst at E4 while changing a and b and pulsing start during E1–E3 → no done pulse; diff, bout, overflow and busy all 0 after reset. A new start with a=9, b=4 then yields diff=5 with done 8 edges later.

Source files
------------

// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub
//
// Multi-cycle subtractor: diff = a - b - bin, evaluated one DIGIT-wide slice
// per clock, least-significant slice first, with the borrow between slices
// held in a register. Trades latency (WIDTH/DIGIT cycles in RUN) for a single
// DIGIT-wide subtract cell.
//
// Optional build macro: NIBBLE_SERIAL_SUB_SAT_EN
//    When defined, a signed overflow saturates diff to the most positive
//    (a[MSB]=0) or most negative (a[MSB]=1) value. bout and overflow are
//    always taken from the unsaturated arithmetic. Latency is identical.
//
// Handshake: start is sampled only while busy=0. An accepted start captures
//    a, b and bin. Exactly WIDTH/DIGIT edges later done pulses for one cycle,
//    with diff/bout/overflow already updated. busy covers RUN and DONE, and
//    start is ignored while busy=1.
//
// Ports:
//    clk       in   rising-edge clock
//    rst       in   asynchronous active-high reset (aborts any operation)
//    start     in   operation request
//    a         in   [WIDTH-1:0] minuend
//    b         in   [WIDTH-1:0] subtrahend
//    bin       in   borrow-in
//    busy      out  high in RUN and DONE
//    done      out  one-cycle completion pulse
//    diff      out  [WIDTH-1:0] result, held until the next completion
//    bout      out  unsigned borrow-out (a < b + bin)
//    overflow  out  signed overflow flag
module nibble_serial_sub #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             overflow
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;     // minuend, shifted right one slice per edge
   logic [WIDTH-1:0] b_sh;     // subtrahend, shifted right one slice per edge
   logic [WIDTH-1:0] res_sh;   // result slices enter at the top
   logic             borrow;   // borrow into the current slice
   logic             a_msb;    // operand sign bits kept for the overflow test
   logic             b_msb;
   logic [CW-1:0]    cnt;      // index of the slice being computed

   // Combinational slice cell and the result as it will look after this edge.
   logic [DIGIT:0]   slice_full;
   logic [WIDTH-1:0] res_next;
   logic             ovf_next;
   logic [WIDTH-1:0] diff_next;
   logic             last_slice;

   always_comb begin
      slice_full = {1'b0, a_sh[DIGIT-1:0]}
                 - {1'b0, b_sh[DIGIT-1:0]}
                 - {{DIGIT{1'b0}}, borrow};
      // New slice goes into the top; after N shifts slice 0 sits at the bottom.
      res_next   = (res_sh >> DIGIT)
                 | (WIDTH'(slice_full[DIGIT-1:0]) << (WIDTH - DIGIT));
      ovf_next   = (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
      last_slice = (cnt == CW'(N - 1));
`ifdef NIBBLE_SERIAL_SUB_SAT_EN
      if (ovf_next) begin
         diff_next = a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                           : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         diff_next = res_next;
      end
`else
      diff_next = res_next;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         borrow   <= 1'b0;
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         diff     <= '0;
         bout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  borrow <= bin;
                  a_msb  <= a[WIDTH-1];
                  b_msb  <= b[WIDTH-1];
                  res_sh <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end

            RUN: begin
               a_sh   <= a_sh >> DIGIT;
               b_sh   <= b_sh >> DIGIT;
               res_sh <= res_next;
               borrow <= slice_full[DIGIT];
               cnt    <= cnt + CW'(1);
               if (last_slice) begin
                  diff     <= diff_next;
                  bout     <= slice_full[DIGIT];
                  overflow <= ovf_next;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end

            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Testbench for nibble_serial_sub (WIDTH=32, DIGIT=4): a table of directed
// vectors with hand-computed results, plus a reset-abort sequence.
// Expectations follow NIBBLE_SERIAL_SUB_SAT_EN when it is defined.
module tb_nibble_serial_sub;

   localparam int W = 32;
   localparam int N = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
   logic         overflow;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   nibble_serial_sub #(.WIDTH(W), .DIGIT(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .bin      (bin),
      .busy     (busy),
      .done     (done),
      .diff     (diff),
      .bout     (bout),
      .overflow (overflow)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- vector table ----------------
   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] diff;   // modular result
      logic [W-1:0] sat;    // result when saturation is compiled in
      logic         bout;
      logic         ovf;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [W-1:0] act,
                        input logic [W-1:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // One operation: start at E0, random start noise while busy, done must
   // appear exactly N edges after E0, and results must hold one cycle later.
   task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vbin, input logic [W-1:0] ediff,
                         input logic ebout, input logic eovf);
      int cyc;
      @(negedge clk);
      a = va; b = vb; bin = vbin; start = 1'b1;
      @(posedge clk);          // E0
      #1;
      check("busy_after_start", W'(busy), W'(1));
      cyc = 0;
      while (cyc < 20) begin
         // operands change and start chatters while busy: must be ignored
         a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
         start = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         cyc++;
         if (done) break;
      end
      start = 1'b0;
      check("done_latency", W'(cyc), W'(N));
      check("diff", diff, ediff);
      check("bout", W'(bout), W'(ebout));
      check("overflow", W'(overflow), W'(eovf));
      @(posedge clk);          // E0+N+1
      #1;
      check("done_one_cycle", W'(done), W'(0));
      check("busy_cleared", W'(busy), W'(0));
      check("diff_held", diff, ediff);
   endtask

   initial begin
      int quiet;
      vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 32'h0000_0002, 1'b0, 1'b0};
      vecs[1] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 32'h0000_0006, 32'h0000_0006, 1'b0, 1'b0};
      vecs[2] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1};
      vecs[4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1};
      vecs[5] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[8] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1};
      vecs[9] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 32'h4B4B_4B4B, 32'h8000_0000, 1'b0, 1'b1};

      // ---------------- reset ----------------
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      #1;
      check("rst_busy", W'(busy), W'(0));
      check("rst_done", W'(done), W'(0));
      check("rst_diff", diff, W'(0));
      check("rst_bout_ovf", W'({bout, overflow}), W'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // ---------------- table ----------------
      for (int i = 0; i < 10; i++) begin
`ifdef NIBBLE_SERIAL_SUB_SAT_EN
         run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].sat, vecs[i].bout, vecs[i].ovf);
`else
         run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout, vecs[i].ovf);
`endif
      end

      // ---------------- reset aborts a running operation ----------------
      @(negedge clk);
      a = 32'd5; b = 32'd3; bin = 1'b0; start = 1'b1;
      @(posedge clk);          // E0
      for (int e = 1; e <= 3; e++) begin
         #1;
         a = $urandom; b = $urandom; start = ~start;
         @(posedge clk);       // E1..E3
      end
      @(negedge clk);
      start = 1'b0;
      rst = 1'b1;              // lands before E4
      #1;
      check("abort_busy", W'(busy), W'(0));
      check("abort_diff", diff, W'(0));
      check("abort_bout_ovf", W'({bout, overflow}), W'(0));
      @(negedge clk);
      rst = 1'b0;
      quiet = 1;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         if (done || busy) quiet = 0;
      end
      check("abort_no_done", W'(quiet), W'(1));
      check("abort_diff_still_zero", diff, W'(0));

      run_op(32'd9, 32'd4, 1'b0, 32'd5, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   // Global guard so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
